uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single byte-wide console TX stream (the link into axi_jtaguart)
//   between N requesters, e.g. the yarvi_soc HTIF console and a debug/status printer.
//   Arbitration is per message: a requester keeps ownership until it sends the EOM byte
//   or goes idle for TIMEOUT cycles. Output bytes from different owners never interleave
//   mid-line.
//   One registered output stage decouples requesters from the sink.
// PARAMETERS
//   N        2      number of requesters, 2..8
//   EOM      8'h0A  end-of-message byte; accepting it releases ownership
//   TIMEOUT  255    idle cycles while owned before forced release; >=1
// PORTS
//   clock      in   1    system clock
//   reset      in   1    asynchronous, active-high reset
//   req_valid  in   N    per-requester byte valid
//   req_data   in   8*N  per-requester byte; requester i uses bits [8*i+7:8*i]
//   req_ready  out  N    per-requester accept; at most one bit high
//   tx_valid   out  1    output byte valid (registered)
//   tx_data    out  8    output byte (registered)
//   tx_ready   in   1    sink accept
//   grant      out  N    one-hot current owner, all zero when unowned (registered)
//   locked     out  1    1 while an owner holds the stream (registered)
// BEHAVIOUR
//   Reset (async): state=IDLE; grant=0, locked=0, tx_valid=0, tx_data=0; rr_ptr=0; idle_cnt=0.
//   Output stage: out_free = !tx_valid | tx_ready.
//     - On accept: tx_data<=byte, tx_valid<=1.
//     - Else if tx_ready: tx_valid<=0.
//     - tx_data is held stable while tx_valid & !tx_ready.
//   req_ready[i] = locked & grant[i] & out_free; combinational, all others 0.
//   Accept = req_valid[owner] & req_ready[owner].
//   IDLE:
//     - req_ready=0.
//     - If any req_valid: owner = first valid index scanning rr_ptr, rr_ptr+1, ... mod N.
//     - Then grant<=onehot(owner), locked<=1, idle_cnt<=0, next state OWNED.
//   OWNED:
//     - Accept of EOM byte: byte still goes out; grant<=0, locked<=0, rr_ptr<=(owner+1)%N,
//       next state IDLE.
//     - Accept of other byte: idle_cnt<=0.
//     - No accept and !req_valid[owner]: idle_cnt++. On reaching TIMEOUT: release as for
//       EOM, no byte sent. A stalled sink (req_valid high, not accepted) does not count idle.
//   Latency:
//     - req_valid in IDLE at cycle 0 -> grant/locked at cycle 1.
//     - First accept at cycle 1 if out_free.
//     - tx_valid at cycle 2.
//   Throughput: 1 byte/cycle while owned and tx_ready=1.
//   Release and re-arbitration never share a cycle: at least one IDLE cycle between owners.
//   The output register keeps draining in IDLE.
//   Simultaneous requests: round-robin from rr_ptr. A releasing owner is lowest priority
//   next round, so no starvation.
//   idle_cnt width $clog2(TIMEOUT+1); saturates at TIMEOUT, no wrap.
//   Owner deasserting valid mid-message: ownership kept until TIMEOUT; other requesters wait.
//   Reset mid-message: pending output byte discarded, tx_valid=0 immediately, arbitration
//   restarts at requester 0.
// TESTING
//   1. Reset: assert mid-stream -> tx_valid, grant, locked = 0 asynchronously;
//      after release, first grant goes to req 0.
//   2. Single line: req0 sends "hi\n", tx_ready=1 -> tx_data 68,69,0A on cycles 2,3,4;
//      locked drops at cycle 4; grant=0 at cycle 4.
//   3. Contention: req0 and req1 both valid from cycle 0, each sending "A\n" / "B\n"
//      -> output 41,0A,42,0A, no interleave; grant 01 then 10 after 1 idle cycle.
//   4. Backpressure: tx_ready=0 for 5 cycles while owned -> tx_data stable, req_ready=0,
//      no byte lost or duplicated; idle_cnt unchanged.
//   5. Timeout (TIMEOUT=4): req0 sends "x", drops valid; req1 valid
//      -> req0 released 4 cycles after the last accept; req1 granted the next cycle.
//   6. Fairness N=3: all requesters stream lines continuously
//      -> grant order 0,1,2,0,1,2; each requester gets a turn within 3 messages.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide console TX stream between N requesters, arbitrating per message.
// Ownership is held until the EOM byte is accepted or the owner idles for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int          N       = 2,
    parameter logic [7:0]  EOM     = 8'h0A,
    parameter int          TIMEOUT = 255
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    output logic [N-1:0]   req_ready,
    output logic           tx_valid,
    output logic [7:0]     tx_data,
    input  logic           tx_ready,
    output logic [N-1:0]   grant,
    output logic           locked
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]    state;
    logic [PW-1:0] owner;
    logic [PW-1:0] rr_ptr;
    logic [CW-1:0] idle_cnt;

    logic          out_free;
    logic          owner_valid;
    logic [7:0]    owner_data;
    logic          accept;
    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] owner_next;
    logic [CW-1:0] idle_inc;
    logic          idle_expired;

    assign out_free    = !tx_valid || tx_ready;
    assign req_ready   = grant & {N{locked & out_free}};
    assign accept      = |(req_valid & req_ready);
    assign owner_valid = req_valid[owner];
    assign owner_data  = req_data[8*owner +: 8];
    assign owner_next  = (owner == PW'(N - 1)) ? '0 : owner + PW'(1);

    // Idle counter saturates at TIMEOUT; release fires on the cycle it gets there.
    assign idle_inc     = (idle_cnt == TIMEOUT_CNT) ? idle_cnt : idle_cnt + CW'(1);
    assign idle_expired = (idle_inc == TIMEOUT_CNT);

    // Round-robin scan from rr_ptr: iterate backwards so the nearest valid index wins.
    always_comb begin
        // NOTE: every comb output gets a default up front so no path can infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % N]) begin
                pick_found = 1'b1;
                pick_idx   = PW'((int'(rr_ptr) + k) % N);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            idle_cnt <= '0;
            grant    <= '0;
            locked   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state    <= ST_OWNED;
                        owner    <= pick_idx;
                        grant    <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        locked   <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                ST_OWNED: begin
                    if (accept) begin
                        if (owner_data == EOM) begin
                            state  <= ST_IDLE;
                            grant  <= '0;
                            locked <= 1'b0;
                            rr_ptr <= owner_next;
                        end else begin
                            idle_cnt <= '0;
                        end
                    end else if (!owner_valid) begin
                        idle_cnt <= idle_inc;
                        if (idle_expired) begin
                            state  <= ST_IDLE;
                            grant  <= '0;
                            locked <= 1'b0;
                            rr_ptr <= owner_next;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register keeps draining regardless of arbitration state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (accept) begin
            tx_valid <= 1'b1;
            tx_data  <= owner_data;
        end else if (tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a queue-driven requester model and a sink log,
// checked against hand-computed cycle timing and byte order.
module tb_uart_tx_arbiter;

    localparam int N = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready = 1'b1;
    logic [N-1:0]   grant;
    logic           locked;

    uart_tx_arbiter #(.N(N), .EOM(8'h0A), .TIMEOUT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .locked    (locked)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] msg [N][16];
    int         head [N];
    int         len  [N];
    logic [7:0] rx [64];
    int         rn = 0;
    logic [N-1:0] glog [16];
    int         gn = 0;
    logic       locked_seen = 1'b0;
    logic [N-1:0] acc;

    logic [7:0] exp_t3 [4]  = '{8'h41, 8'h0A, 8'h42, 8'h0A};
    logic [7:0] exp_t4 [4]  = '{8'h50, 8'h51, 8'h52, 8'h0A};
    logic [7:0] exp_t5 [3]  = '{8'h78, 8'h79, 8'h0A};
    logic [7:0] exp_t6 [12] = '{8'h61, 8'h0A, 8'h62, 8'h0A, 8'h63, 8'h0A,
                                8'h61, 8'h0A, 8'h62, 8'h0A, 8'h63, 8'h0A};
    logic [N-1:0] exp_g6 [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            len[i]  = 0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] b);
        msg[r][len[r]] = b;
        len[r]++;
    endtask

    // One clock: drive requesters from their queues, log sink bytes just before the
    // edge, then advance each requester whose byte was accepted.
    task automatic cycle();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = (head[i] < len[i]);
            req_data[8*i +: 8]  = (head[i] < len[i]) ? msg[i][head[i]] : 8'h00;
        end
        if (locked && !locked_seen && gn < 16) begin
            glog[gn] = grant;
            gn++;
        end
        locked_seen = locked;
        #1;
        acc = req_valid & req_ready;
        if (tx_valid && tx_ready && rn < 64) begin
            rx[rn] = tx_data;
            rn++;
        end
        @(negedge clock);
        for (int i = 0; i < N; i++)
            if (acc[i]) head[i]++;
    endtask

    initial begin
        clear_queues();
        @(negedge clock);
        @(negedge clock);
        check("rst tx_valid", tx_valid, 0);
        check("rst tx_data", tx_data, 0);
        check("rst grant", grant, 0);
        check("rst locked", locked, 0);
        check("rst req_ready", req_ready, 0);
        reset = 1'b0;

        // Contention: req0 "A\n", req1 "B\n" both valid from cycle 0.
        push(0, 8'h41); push(0, 8'h0A);
        push(1, 8'h42); push(1, 8'h0A);
        rn = 0;
        cycle(); check("t3 c1 grant", grant, 3'b001);
        cycle();
        cycle(); check("t3 c3 grant idle", grant, 3'b000);
        cycle(); check("t3 c4 grant", grant, 3'b010);
        repeat (5) cycle();
        check("t3 rx count", rn, 4);
        for (int k = 0; k < 4; k++) check($sformatf("t3 rx%0d", k), rx[k], exp_t3[k]);

        // Single line "hi\n" from req0.
        clear_queues();
        push(0, 8'h68); push(0, 8'h69); push(0, 8'h0A);
        rn = 0;
        cycle();
        check("t2 c1 grant", grant, 3'b001);
        check("t2 c1 locked", locked, 1);
        check("t2 c1 tx_valid", tx_valid, 0);
        check("t2 c1 req_ready", req_ready, 3'b001);
        cycle(); check("t2 c2 tx_data", tx_data, 8'h68); check("t2 c2 tx_valid", tx_valid, 1);
        cycle(); check("t2 c3 tx_data", tx_data, 8'h69);
        cycle();
        check("t2 c4 tx_data", tx_data, 8'h0A);
        check("t2 c4 locked", locked, 0);
        check("t2 c4 grant", grant, 3'b000);
        cycle(); check("t2 c5 tx_valid", tx_valid, 0);
        check("t2 rx count", rn, 3);

        // Backpressure while req1 owns the stream.
        clear_queues();
        push(1, 8'h50); push(1, 8'h51); push(1, 8'h52); push(1, 8'h0A);
        rn = 0;
        cycle(); check("t4 c1 grant", grant, 3'b010);
        cycle(); check("t4 c2 tx_data", tx_data, 8'h50);
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("t4 stall%0d tx_data", k), tx_data, 8'h50);
            check($sformatf("t4 stall%0d tx_valid", k), tx_valid, 1);
            check($sformatf("t4 stall%0d req_ready", k), req_ready, 3'b000);
            check($sformatf("t4 stall%0d grant", k), grant, 3'b010);
        end
        tx_ready = 1'b1;
        repeat (8) cycle();
        check("t4 rx count", rn, 4);
        for (int k = 0; k < 4; k++) check($sformatf("t4 rx%0d", k), rx[k], exp_t4[k]);
        check("t4 released", locked, 0);

        // Timeout: req0 sends "x" then goes quiet while req1 waits.
        clear_queues();
        push(0, 8'h78);
        push(1, 8'h79); push(1, 8'h0A);
        rn = 0;
        cycle(); check("t5 c1 grant", grant, 3'b001);
        cycle(); check("t5 c2 tx_data", tx_data, 8'h78);
        cycle(); check("t5 c3 req_ready", req_ready, 3'b001);
        cycle();
        cycle(); check("t5 c5 grant held", grant, 3'b001); check("t5 c5 locked", locked, 1);
        cycle(); check("t5 c6 grant released", grant, 3'b000); check("t5 c6 locked", locked, 0);
        cycle(); check("t5 c7 grant", grant, 3'b010);
        repeat (5) cycle();
        check("t5 rx count", rn, 3);
        for (int k = 0; k < 3; k++) check($sformatf("t5 rx%0d", k), rx[k], exp_t5[k]);

        // Reset in the middle of a req1 message.
        clear_queues();
        for (int k = 0; k < 8; k++) push(1, 8'h7A);
        cycle(); cycle(); cycle();
        check("t1 pre tx_valid", tx_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("t1 async tx_valid", tx_valid, 0);
        check("t1 async grant", grant, 3'b000);
        check("t1 async locked", locked, 0);
        clear_queues();
        @(negedge clock);
        cycle(); cycle();
        reset = 1'b0;

        // Fairness: all three stream two lines each.
        for (int r = 0; r < N; r++) begin
            push(r, 8'h61 + 8'(r)); push(r, 8'h0A);
            push(r, 8'h61 + 8'(r)); push(r, 8'h0A);
        end
        rn = 0;
        gn = 0;
        locked_seen = 1'b0;
        for (int k = 0; k < 80 && rn < 12; k++) cycle();
        check("t6 rx count", rn, 12);
        check("t6 grant count", gn, 6);
        for (int k = 0; k < 6; k++) check($sformatf("t6 grant%0d", k), glog[k], exp_g6[k]);
        for (int k = 0; k < 12; k++) check($sformatf("t6 rx%0d", k), rx[k], exp_t6[k]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
